// File: rtl/pipelined_carry_select_adder.sv
// Pipelined carry-select adder/subtractor with a valid/ready handshake.
// Each stage resolves WIDTH/BLOCK/STAGES carry-select blocks and registers the
// carry at its upper boundary. The final stage register is the output register.
module pipelined_carry_select_adder #(
  parameter int WIDTH  = 32,
  parameter int BLOCK  = 8,
  parameter int STAGES = 4
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             in_valid,
  output logic             in_ready,
  input  logic [WIDTH-1:0] a,
  input  logic [WIDTH-1:0] b,
  input  logic             cin,
  input  logic             sub,
  output logic             out_valid,
  input  logic             out_ready,
  output logic [WIDTH-1:0] sum,
  output logic             c_out,
  output logic             ovf
);

  localparam int NBLK = WIDTH / BLOCK;
  localparam int BPS  = NBLK / STAGES;

  generate
    if (WIDTH < 2 || BLOCK < 1 || (WIDTH % BLOCK) != 0 ||
        STAGES < 1 || (NBLK % STAGES) != 0) begin : g_bad_params
      $error("pipelined_carry_select_adder: illegal WIDTH/BLOCK/STAGES combination");
    end
  endgenerate

  // Handshake: a transfer happens on a rising edge where valid && ready are
  // both high, on either port. Stage s loads when it is empty or when every
  // stage downstream of it moves this cycle (free[s]); in_ready is free[0],
  // so it depends combinationally on out_ready. There is no skid buffer.

  // Stage registers; the operand registers carry the not-yet-consumed bits.
  logic [STAGES-1:0] v_q;
  logic [WIDTH-1:0]  a_q [STAGES];
  logic [WIDTH-1:0]  b_q [STAGES];
  logic [WIDTH-1:0]  s_q [STAGES];
  logic              c_q [STAGES];
  logic              ovf_q;

  // Per-stage combinational view: what enters stage s and what it produces.
  logic              op_v [STAGES];
  logic [WIDTH-1:0]  op_a [STAGES];
  logic [WIDTH-1:0]  op_b [STAGES];
  logic [WIDTH-1:0]  op_s [STAGES];
  logic              op_c [STAGES];
  logic [WIDTH-1:0]  nx_s [STAGES];
  logic              nx_c [STAGES];
  logic              ovf_nx;
  logic [STAGES-1:0] free;

  // Stage s may load if out_ready or any stage from s to the output is empty.
  always_comb begin
    free = '0;
    for (int s = 0; s < STAGES; s++) begin
      free[s] = out_ready;
      for (int t = s; t < STAGES; t++) begin
        if (!v_q[t]) free[s] = 1'b1;
      end
    end
  end

  // Carry-select arithmetic: each block forms both candidate sums and the
  // incoming carry picks one; the selected block carry ripples to the next.
  always_comb begin
    logic [BLOCK:0] cand0;
    logic [BLOCK:0] cand1;
    logic           carry;
    cand0  = '0;
    cand1  = '0;
    carry  = 1'b0;
    op_v[0] = in_valid;
    op_a[0] = a;
    op_b[0] = sub ? ~b : b;
    op_s[0] = '0;
    op_c[0] = sub | cin;
    for (int s = 1; s < STAGES; s++) begin
      op_v[s] = v_q[s-1];
      op_a[s] = a_q[s-1];
      op_b[s] = b_q[s-1];
      op_s[s] = s_q[s-1];
      op_c[s] = c_q[s-1];
    end
    for (int s = 0; s < STAGES; s++) begin
      carry   = op_c[s];
      nx_s[s] = op_s[s];
      for (int j = 0; j < NBLK; j++) begin
        if ((j / BPS) == s) begin
          cand0 = {1'b0, op_a[s][j*BLOCK +: BLOCK]} + {1'b0, op_b[s][j*BLOCK +: BLOCK]};
          cand1 = {1'b0, op_a[s][j*BLOCK +: BLOCK]} + {1'b0, op_b[s][j*BLOCK +: BLOCK]}
                + {{BLOCK{1'b0}}, 1'b1};
          nx_s[s][j*BLOCK +: BLOCK] = carry ? cand1[BLOCK-1:0] : cand0[BLOCK-1:0];
          carry = carry ? cand1[BLOCK] : cand0[BLOCK];
        end
      end
      nx_c[s] = carry;
    end
    // Signed overflow uses the already-inverted b, so it covers subtraction.
    ovf_nx = (op_a[STAGES-1][WIDTH-1] == op_b[STAGES-1][WIDTH-1]) &&
             (nx_s[STAGES-1][WIDTH-1] != op_a[STAGES-1][WIDTH-1]);
  end

  // Stage registers advance when free; data only loads with a valid item,
  // so a stalled output holds its value and bubbles carry no new data.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      v_q   <= '0;
      ovf_q <= 1'b0;
      for (int s = 0; s < STAGES; s++) begin
        a_q[s] <= '0;
        b_q[s] <= '0;
        s_q[s] <= '0;
        c_q[s] <= 1'b0;
      end
    end else begin
      for (int s = 0; s < STAGES; s++) begin
        if (free[s]) begin
          v_q[s] <= op_v[s];
          if (op_v[s]) begin
            a_q[s] <= op_a[s];
            b_q[s] <= op_b[s];
            s_q[s] <= nx_s[s];
            c_q[s] <= nx_c[s];
          end
        end
      end
      if (free[STAGES-1] && op_v[STAGES-1]) ovf_q <= ovf_nx;
    end
  end

  assign in_ready  = free[0];
  assign out_valid = v_q[STAGES-1];
  assign sum       = s_q[STAGES-1];
  assign c_out     = c_q[STAGES-1];
  assign ovf       = ovf_q;

endmodule

// File: doc/pipelined_carry_select_adder.md
Name: pipelined_carry_select_adder

Overview:
- Parametrised, pipelined carry-select adder/subtractor with valid/ready handshake.
- Successor to the fixed 32-bit combinational carry-select adder.
- Operand width and block size are generic.
- Each pipeline stage resolves one group of carry-select blocks and registers the carry between stages, so throughput is one operation per clock.
- Sits in the datapath between operand registers and the ALU result mux.

Parameters:
- WIDTH, 32, operand and sum width in bits (>=2).
- BLOCK, 8, bits per carry-select block. WIDTH must be a multiple of BLOCK; elaborate-time check.
- STAGES, 4, pipeline register stages. Must divide WIDTH/BLOCK.

Ports:
- clk  in  1  system clock.
- rst_n  in  1  asynchronous active-low reset.
- in_valid  in  1  operands presented.
- in_ready  out  1  block can accept operands this cycle.
- a  in  WIDTH  operand A.
- b  in  WIDTH  operand B.
- cin  in  1  carry in (ignored when sub=1).
- sub  in  1  1 = compute a - b (b inverted, carry-in forced to 1).
- out_valid  out  1  result valid.
- out_ready  in  1  downstream accepts result.
- sum  out  WIDTH  result.
- c_out  out  1  carry out of MSB (for sub: 1 = no borrow).
- ovf  out  1  signed overflow: (a_msb == b'_msb) && (sum_msb != a_msb), where b' is b after conditional inversion.

Behaviour:
- Reset
  - Asynchronous on rst_n low.
  - All stage valid bits, out_valid, sum, c_out and ovf clear to 0.
  - in_ready = 1 one cycle after rst_n deasserts; combinationally it reflects the empty pipeline.
- Arithmetic
  - b' = sub ? ~b : b; c0 = sub ? 1 : cin.
  - Each BLOCK computes two candidate sums (carry-in 0 and 1).
  - The incoming carry selects the candidate sum and block carry.
  - Stage k handles blocks k*(WIDTH/BLOCK/STAGES) to (k+1)*(WIDTH/BLOCK/STAGES)-1.
  - Result is exact modulo 2^WIDTH; c_out is bit WIDTH of a + b' + c0.
- Pipeline
  - Stage k registers the not-yet-consumed upper operand bits, the partial sum, the boundary carry, and sub_msb information for ovf.
  - Latency is STAGES cycles from an accepted input (in_valid && in_ready at an edge) to out_valid.
- Handshake
  - Input transfer occurs when in_valid && in_ready; output transfer occurs when out_valid && out_ready.
  - Stall: if out_valid && !out_ready, the output holds sum/c_out/ovf stable.
  - Each stage advances only if its successor is empty or advancing; bubbles collapse.
  - in_ready = !stage0_valid || stage0_advances. This is combinational from out_ready through the stage chain; no skid buffer.
  - Throughput is 1/cycle with out_ready held high.
  - in_valid low inserts a bubble.
- Simultaneous events
  - Accept and emit in the same cycle with a full pipeline is legal; occupancy is unchanged.
- Boundary cases
  - All-ones + 1 gives sum = 0, c_out = 1.
  - a - a gives sum = 0, c_out = 1, ovf = 0.
  - 0 - 1 gives sum = all-ones, c_out = 0.
- Reset mid-operation drops all in-flight results; no partial output is emitted.
- Outputs other than out_valid are don't-care when out_valid = 0 but must not be X after reset.

Test Plan:
- Reset then single add: WIDTH=32, a=0xFFFFFFFF, b=0x00000001, cin=0 -> after 4 cycles out_valid=1, sum=0x00000000, c_out=1, ovf=0.
- Subtract: a=0x00000000, b=0x00000001, sub=1 -> sum=0xFFFFFFFF, c_out=0, ovf=0; then a=0x80000000, b=0x00000001, sub=1 -> sum=0x7FFFFFFF, ovf=1, c_out=1.
- Back-to-back streaming of 100 random operand pairs with out_ready=1 -> one result per cycle after 4-cycle fill, in order, each matching the a+b+cin reference model.
- Backpressure: fill the pipeline, drop out_ready for 5 cycles -> in_ready falls once all stages are full; the held sum stays stable; no loss or duplication after release.
- Reset mid-stream: assert rst_n=0 with 3 items in flight -> out_valid=0 immediately, and no stale result appears after reset release.
- Parameter sweep: WIDTH=16/BLOCK=4/STAGES=2 and WIDTH=64/BLOCK=8/STAGES=8 with random and corner vectors (0, all-ones, 0x8000...) -> exact match, latency equals STAGES.
